nios2_nios2_cpu_debug_ocimem_seq: RTL and testbench

Sysclk-domain sequencer that executes JTAG debug memory commands against the Nios II on-chip debug RAM. It sits directly downstream of the debug-slave sysclk stage. It consumes that stage's `jdo` word and its `take_action_ocimem_*` strobes, runs one Avalon-style access per command, and returns `MonDReg`, `monitor_ready` and `monitor_error` to the debug-slave TCK stage for shift-out.

---
 rtl/nios2_nios2_cpu_debug_ocimem_seq_if.sv | 21 ++
 rtl/nios2_nios2_cpu_debug_ocimem_seq.sv | 173 +++++++++++++++++
 tb/tb_nios2_nios2_cpu_debug_ocimem_seq.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios2_nios2_cpu_debug_ocimem_seq_if.sv
// Avalon-style bus between the OCI debug-memory sequencer (master) and the debug RAM (slave).
interface nios2_nios2_cpu_debug_ocimem_seq_if #(
  parameter int unsigned ADDR_W = 9
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata;
  logic              mem_waitrequest;

  modport master (
    output mem_address, mem_read, mem_write, mem_writedata,
    input  mem_readdata, mem_waitrequest
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_writedata,
    output mem_readdata, mem_waitrequest
  );
endinterface

// File: rtl/nios2_nios2_cpu_debug_ocimem_seq.sv
// Sysclk-domain sequencer running one debug-RAM access per JTAG OCI memory command.
// Optional stall timeout: define OCIMEM_TIMEOUT_EN.
module nios2_nios2_cpu_debug_ocimem_seq #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  nios2_nios2_cpu_debug_ocimem_seq_if.master mem,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       dreg_q, dreg_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              any_strobe_c;
  logic              aborted_c;
  logic              unused_ok;

`ifdef OCIMEM_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;
  assign aborted_c = abort_q;
`else
  assign aborted_c = 1'b0;
`endif

  assign any_strobe_c = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign unused_ok    = ^{jdo[37:35], jdo[2:0], 1'(TIMEOUT)};

  assign mem.mem_address   = addr_q;
  assign mem.mem_read      = rd_q;
  assign mem.mem_write     = wr_q;
  assign mem.mem_writedata = wdata_q;
  assign MonDReg           = dreg_q;
  assign monitor_ready     = ready_q;
  assign monitor_error     = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      dreg_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
`ifdef OCIMEM_TIMEOUT_EN
      cnt_q   <= '0;
      abort_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dreg_q  <= dreg_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ready_q <= ready_d;
      err_q   <= err_d;
`ifdef OCIMEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
`endif
    end
  end

  // Read data lands in MonDReg on the accepting edge so it is visible one cycle before ready.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dreg_d  = dreg_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    ready_d = ready_q;
    err_d   = err_q;
`ifdef OCIMEM_TIMEOUT_EN
    cnt_d   = cnt_q;
    abort_d = abort_q;
`endif

    case (state_q)
      S_IDLE: begin
`ifdef OCIMEM_TIMEOUT_EN
        cnt_d   = '0;
        abort_d = 1'b0;
`endif
        if (take_action_ocimem_a) begin
          addr_d = ADDR_W'(jdo[26:18]);
          if (jdo[16]) err_d = 1'b0;
          if (jdo[17]) begin
            state_d = S_RD;
            rd_d    = 1'b1;
            ready_d = 1'b0;
          end
        end else if (take_action_ocimem_b) begin
          wdata_d = jdo[34:3];
          state_d = S_WR;
          wr_d    = 1'b1;
          ready_d = 1'b0;
        end else if (take_no_action_ocimem_a) begin
          state_d = S_RD;
          rd_d    = 1'b1;
          ready_d = 1'b0;
        end
      end
      S_RD: begin
        if (!mem.mem_waitrequest) begin
          dreg_d  = mem.mem_readdata;
          rd_d    = 1'b0;
          state_d = S_DONE;
        end
`ifdef OCIMEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rd_d    = 1'b0;
          err_d   = 1'b1;
          abort_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_WR: begin
        if (!mem.mem_waitrequest) begin
          wr_d    = 1'b0;
          state_d = S_DONE;
        end
`ifdef OCIMEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          wr_d    = 1'b0;
          err_d   = 1'b1;
          abort_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_DONE: begin
        if (!aborted_c) addr_d = addr_q + ADDR_W'(1);
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Commands arriving while busy are dropped and flagged
    if (state_q != S_IDLE && any_strobe_c) err_d = 1'b1;
  end

endmodule

// File: tb/tb_nios2_nios2_cpu_debug_ocimem_seq.sv
// Scoreboard bench for the OCI debug-memory sequencer with a RAM model and a reference model.
module tb_nios2_nios2_cpu_debug_ocimem_seq;
  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned DEPTH   = 512;
  localparam int unsigned TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        ta_a, ta_b, tna_a;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;

  nios2_nios2_cpu_debug_ocimem_seq_if #(.ADDR_W(ADDR_W)) bus ();

  nios2_nios2_cpu_debug_ocimem_seq #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta_a),
    .take_action_ocimem_b    (ta_b),
    .take_no_action_ocimem_a (tna_a),
    .mem                     (bus),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dreg;
    logic [8:0]  addr;
    int          lat;
    int          t0;
    bit          is_rd;
  } exp_t;

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] data;
  } wexp_t;

  exp_t        sb_q[$];
  wexp_t       wq[$];
  logic [31:0] mem_arr [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [8:0]  ref_addr;
  logic [31:0] ref_dreg;
  logic        ref_err;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          stall_left = 0;
  int          req_run = 0;
  logic        req_prev = 1'b0;
  logic        ready_prev = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s t=%0t", nm, $time);
  endtask

  function automatic logic [37:0] rnd38();
    return 38'({$urandom(), $urandom()});
  endfunction

  // RAM model: programmable stall count per access, commits and checks writes when accepted
  always @(negedge clk) begin
    wexp_t w;
    if ((bus.mem_read || bus.mem_write) && stall_left > 0) begin
      bus.mem_waitrequest = 1'b1;
      stall_left--;
    end else begin
      bus.mem_waitrequest = 1'b0;
    end
    bus.mem_readdata = mem_arr[bus.mem_address];
    if (!reset && bus.mem_read && bus.mem_write) fail("rd_wr_overlap");
    if (!reset && bus.mem_write && !bus.mem_waitrequest) begin
      if (wq.size() == 0) begin
        fail("unexpected_write");
      end else begin
        w = wq.pop_front();
        chk("wr_addr", 32'(bus.mem_address), 32'(w.addr));
        chk("wr_data", bus.mem_writedata, w.data);
      end
      mem_arr[bus.mem_address] = bus.mem_writedata;
    end
  end

  // Monitor: request-fall and ready-rise events are compared against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    logic req;
    req = bus.mem_read | bus.mem_write;
    if (!reset) begin
      if (req) req_run++;
      if (req_prev && !req) begin
        if (sb_q.size() == 0) begin
          fail("unexpected_req_end");
        end else begin
          chk("req_len", 32'(req_run), 32'(sb_q[0].lat - 2));
          if (sb_q[0].is_rd) chk("rd_dreg", MonDReg, sb_q[0].dreg);
        end
        req_run = 0;
      end
      if (!ready_prev && monitor_ready) begin
        if (sb_q.size() == 0) begin
          fail("unexpected_ready");
        end else begin
          e = sb_q.pop_front();
          chk("done_dreg", MonDReg, e.dreg);
          chk("done_addr", 32'(bus.mem_address), 32'(e.addr));
          chk("done_err", 32'(monitor_error), 32'(ref_err));
          chk("done_lat", 32'(cyc - e.t0), 32'(e.lat));
        end
      end
    end else begin
      req_run = 0;
    end
    req_prev   = req;
    ready_prev = monitor_ready;
  end

  task automatic pulse(input logic a, input logic b, input logic na, input logic [37:0] j);
    jdo = j; ta_a = a; ta_b = b; tna_a = na;
    @(negedge clk);
    ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0; jdo = rnd38();
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb_q.size() != 0 || wq.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      fail("completion_timeout");
      sb_q.delete();
      wq.delete();
    end
  endtask

  task automatic model_read(input int t0, input int stall);
    exp_t e;
    ref_dreg = ref_mem[ref_addr];
    ref_addr = 9'(ref_addr + 1);
    e.dreg = ref_dreg; e.addr = ref_addr; e.lat = 3 + stall; e.t0 = t0; e.is_rd = 1'b1;
    sb_q.push_back(e);
  endtask

  task automatic do_load(input logic [8:0] a, input bit rd, input bit clr, input int stall,
                         input bit with_b, input bit with_na);
    logic [37:0] j;
    int t0;
    j = rnd38();
    j[26:18] = a; j[17] = rd; j[16] = clr;
    @(negedge clk);
    t0 = cyc;
    stall_left = stall;
    ref_addr = a;
    if (clr) ref_err = 1'b0;
    if (rd) model_read(t0, stall);
    pulse(1'b1, with_b, with_na, j);
    if (rd) begin
      wait_done();
    end else begin
      chk("load_addr", 32'(bus.mem_address), 32'(a));
      chk("load_ready", 32'(monitor_ready), 32'd1);
      chk("load_err", 32'(monitor_error), 32'(ref_err));
      chk("load_no_write", 32'(bus.mem_write), 32'd0);
    end
  endtask

  task automatic do_write(input logic [31:0] d, input int stall, input bit with_na);
    logic [37:0] j;
    exp_t  e;
    wexp_t w;
    int t0;
    j = rnd38();
    j[34:3] = d;
    @(negedge clk);
    t0 = cyc;
    stall_left = stall;
    w.addr = ref_addr; w.data = d;
    wq.push_back(w);
    ref_mem[ref_addr] = d;
    ref_addr = 9'(ref_addr + 1);
    e.dreg = ref_dreg; e.addr = ref_addr; e.lat = 3 + stall; e.t0 = t0; e.is_rd = 1'b0;
    sb_q.push_back(e);
    pulse(1'b0, 1'b1, with_na, j);
    wait_done();
  endtask

  task automatic do_read_na(input int stall);
    @(negedge clk);
    stall_left = stall;
    model_read(cyc, stall);
    pulse(1'b0, 1'b0, 1'b1, rnd38());
    wait_done();
  endtask

  task automatic apply_reset_and_check();
    reset = 1'b1;
    stall_left = 0;
    sb_q.delete();
    wq.delete();
    @(negedge clk);
    chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
    @(negedge clk);
    chk("rst_addr", 32'(bus.mem_address), 32'd0);
    chk("rst_dreg", MonDReg, 32'd0);
    chk("rst_wdata", bus.mem_writedata, 32'd0);
    chk("rst_ready", 32'(monitor_ready), 32'd1);
    chk("rst_err", 32'(monitor_error), 32'd0);
    reset = 1'b0;
    ref_addr = '0; ref_dreg = '0; ref_err = 1'b0;
  endtask

  initial begin
    exp_t e;
    int t0;
    reset = 1'b1;
    jdo = '0; ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0;
    bus.mem_waitrequest = 1'b0;
    bus.mem_readdata = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_arr[i] = $urandom();
      ref_mem[i] = mem_arr[i];
    end
    mem_arr[16] = 32'hDEADBEEF;
    ref_mem[16] = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    apply_reset_and_check();

    // Load-then-read, write with address wrap, read-back
    do_load(9'h010, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    do_load(9'h1FF, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    do_write(32'h12345678, 0, 1'b0);
    chk("wrap_addr", 32'(bus.mem_address), 32'h000);
    do_load(9'h1FF, 1'b1, 1'b0, 0, 1'b0, 1'b0);

    // Five-cycle stall on a read
    do_load(9'h020, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    do_read_na(5);

    // Busy collision during a stalled read, then error clear
    @(negedge clk);
    stall_left = 5;
    model_read(cyc, 5);
    pulse(1'b0, 1'b0, 1'b1, rnd38());
    ref_err = 1'b1;
    pulse(1'b0, 1'b0, 1'b1, rnd38());
    chk("collision_err", 32'(monitor_error), 32'd1);
    wait_done();
    do_load(9'h030, 1'b0, 1'b1, 0, 1'b0, 1'b0);

    // Simultaneous load-only and write strobes: load wins
    do_load(9'h040, 1'b0, 1'b0, 0, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int op, stall;
      logic [8:0] a9;
      op = $urandom_range(0, 4);
      stall = $urandom_range(0, 3);
      a9 = 9'($urandom_range(0, 511));
      case (op)
        0: do_load(a9, 1'b0, 1'($urandom_range(0, 1)), 0, 1'b0, 1'b0);
        1: do_load(a9, 1'b1, 1'($urandom_range(0, 1)), stall, 1'b0, 1'b0);
        2: do_write($urandom(), stall, 1'($urandom_range(0, 1)));
        3: do_read_na(stall);
        default: do_load(a9, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), stall,
                         1'b1, 1'($urandom_range(0, 1)));
      endcase
    end

`ifdef OCIMEM_TIMEOUT_EN
    // Stuck waitrequest: access aborts after TIMEOUT stalled cycles
    @(negedge clk);
    t0 = cyc;
    stall_left = 100000;
    e.dreg = ref_dreg; e.addr = ref_addr; e.lat = 2 + int'(TIMEOUT); e.t0 = t0; e.is_rd = 1'b1;
    sb_q.push_back(e);
    ref_err = 1'b1;
    pulse(1'b0, 1'b0, 1'b1, rnd38());
    wait_done();
    stall_left = 0;
`else
    // Stuck waitrequest: request stays asserted until reset
    @(negedge clk);
    t0 = cyc;
    stall_left = 100000;
    pulse(1'b0, 1'b0, 1'b1, rnd38());
    repeat (1000) @(negedge clk);
    chk("stuck_read", 32'(bus.mem_read), 32'd1);
    chk("stuck_addr", 32'(bus.mem_address), 32'(ref_addr));
    chk("stuck_ready", 32'(monitor_ready), 32'd0);
`endif
    apply_reset_and_check();
    do_load(9'h005, 1'b1, 1'b0, 1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
